// File: rtl/clock_ratio_meter_if.sv
// clock_ratio_meter_if: control/result bundle of the clock ratio meter.
// Optional min/max period results exist when PERIOD_MINMAX_EN is defined.
interface clock_ratio_meter_if #(
   parameter int CW = 32
);
   logic [CW-1:0] gate_cycles;
   logic          start;
   logic          abort;
   logic          busy;
   logic          valid;
   logic          no_signal;
   logic [CW-1:0] edge_count;
   logic [CW-1:0] span;
   logic [CW-1:0] last_period;
`ifdef PERIOD_MINMAX_EN
   logic [CW-1:0] min_period;
   logic [CW-1:0] max_period;

   modport master (
      output gate_cycles, start, abort,
      input  busy, valid, no_signal,
      input  edge_count, span, last_period,
      input  min_period, max_period
   );

   modport slave (
      input  gate_cycles, start, abort,
      output busy, valid, no_signal,
      output edge_count, span, last_period,
      output min_period, max_period
   );
`else
   modport master (
      output gate_cycles, start, abort,
      input  busy, valid, no_signal,
      input  edge_count, span, last_period
   );

   modport slave (
      input  gate_cycles, start, abort,
      output busy, valid, no_signal,
      output edge_count, span, last_period
   );
`endif
endinterface

// File: rtl/clock_ratio_meter.sv
// clock_ratio_meter: counts synchronized meas_clk edges over a clk gate.
// Define PERIOD_MINMAX_EN to add min/max period tracking.
module clock_ratio_meter #(
   parameter int CW          = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               meas_clk,
   clock_ratio_meter_if.slave bus
);

   localparam logic [CW-1:0] ONE = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_GATE
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic prev_q, prev_d;
   logic edge_det;

   logic acc_start;
   logic zero_gate;
   logic timeout;
   logic gate_end;

   logic [CW-1:0] glen_q, glen_d;
   logic [CW-1:0] tcnt_q, tcnt_d;
   logic [CW-1:0] gcnt_q, gcnt_d;
   logic [CW-1:0] ecnt_q, ecnt_d;
   logic [CW-1:0] pcnt_q, pcnt_d;
   logic [CW-1:0] last_q, last_d;
   logic [CW-1:0] lper_q, lper_d;

   logic [CW-1:0] tcnt_inc;
   logic [CW-1:0] gcnt_inc;
   logic [CW-1:0] pcnt_inc;

   logic [CW-1:0] ecnt_n;
   logic [CW-1:0] last_n;
   logic [CW-1:0] lper_n;

   logic busy_q, busy_d;
   logic valid_q, valid_d;
   logic nosig_q, nosig_d;
   logic [CW-1:0] ec_q, ec_d;
   logic [CW-1:0] sp_q, sp_d;
   logic [CW-1:0] lp_q, lp_d;

`ifdef PERIOD_MINMAX_EN
   logic [CW-1:0] mn_q, mn_d;
   logic [CW-1:0] mx_q, mx_d;
   logic [CW-1:0] mn_n;
   logic [CW-1:0] mx_n;
   logic [CW-1:0] minp_q, minp_d;
   logic [CW-1:0] maxp_q, maxp_d;
`endif

   // shift meas_clk through the synchronizer, keep previous synced value
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], meas_clk};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   assign edge_det  = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign acc_start = bus.start & ~bus.abort;
   assign zero_gate = (bus.gate_cycles == '0);

   assign tcnt_inc = tcnt_q + ONE;
   assign gcnt_inc = gcnt_q + ONE;
   assign pcnt_inc = pcnt_q + ONE;

   assign timeout  = (tcnt_inc == glen_q);
   assign gate_end = (gcnt_inc == glen_q);

   // next-state decision
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (acc_start && !zero_gate)
               state_d = S_ARM;
         end
         S_ARM: begin
            if (bus.abort)
               state_d = S_IDLE;
            else if (edge_det)
               state_d = S_GATE;
            else if (timeout)
               state_d = S_IDLE;
         end
         S_GATE: begin
            if (bus.abort || gate_end)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // gate counters as they stand after this cycle's edge, if any
   always_comb begin
      ecnt_n = ecnt_q;
      last_n = last_q;
      lper_n = lper_q;
`ifdef PERIOD_MINMAX_EN
      mn_n = mn_q;
      mx_n = mx_q;
`endif
      if (edge_det) begin
         ecnt_n = ecnt_q + ONE;
         last_n = gcnt_inc;
         lper_n = pcnt_inc;
`ifdef PERIOD_MINMAX_EN
         if (ecnt_q == '0) begin
            mn_n = pcnt_inc;
            mx_n = pcnt_inc;
         end else begin
            if (pcnt_inc < mn_q)
               mn_n = pcnt_inc;
            if (pcnt_inc > mx_q)
               mx_n = pcnt_inc;
         end
`endif
      end
   end

   // per-state counter updates and result publication
   always_comb begin
      glen_d  = glen_q;
      tcnt_d  = tcnt_q;
      gcnt_d  = gcnt_q;
      ecnt_d  = ecnt_q;
      pcnt_d  = pcnt_q;
      last_d  = last_q;
      lper_d  = lper_q;
      busy_d  = busy_q;
      valid_d = 1'b0;
      nosig_d = nosig_q;
      ec_d    = ec_q;
      sp_d    = sp_q;
      lp_d    = lp_q;
`ifdef PERIOD_MINMAX_EN
      mn_d   = mn_q;
      mx_d   = mx_q;
      minp_d = minp_q;
      maxp_d = maxp_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (acc_start) begin
               nosig_d = 1'b0;
               if (zero_gate) begin
                  valid_d = 1'b1;
                  ec_d    = '0;
                  sp_d    = '0;
                  lp_d    = '0;
`ifdef PERIOD_MINMAX_EN
                  minp_d = '0;
                  maxp_d = '0;
`endif
               end else begin
                  glen_d = bus.gate_cycles;
                  tcnt_d = '0;
                  busy_d = 1'b1;
               end
            end
         end
         S_ARM: begin
            if (bus.abort) begin
               busy_d = 1'b0;
            end else if (edge_det) begin
               gcnt_d = '0;
               ecnt_d = '0;
               pcnt_d = '0;
               last_d = '0;
               lper_d = '0;
`ifdef PERIOD_MINMAX_EN
               mn_d = '0;
               mx_d = '0;
`endif
            end else if (timeout) begin
               valid_d = 1'b1;
               busy_d  = 1'b0;
               nosig_d = 1'b1;
               ec_d    = '0;
               sp_d    = '0;
               lp_d    = '0;
`ifdef PERIOD_MINMAX_EN
               minp_d = '0;
               maxp_d = '0;
`endif
            end else begin
               tcnt_d = tcnt_inc;
            end
         end
         S_GATE: begin
            if (bus.abort) begin
               busy_d = 1'b0;
            end else begin
               gcnt_d = gcnt_inc;
               pcnt_d = edge_det ? '0 : pcnt_inc;
               ecnt_d = ecnt_n;
               last_d = last_n;
               lper_d = lper_n;
`ifdef PERIOD_MINMAX_EN
               mn_d = mn_n;
               mx_d = mx_n;
`endif
               if (gate_end) begin
                  valid_d = 1'b1;
                  busy_d  = 1'b0;
                  ec_d    = ecnt_n;
                  sp_d    = last_n;
                  lp_d    = lper_n;
`ifdef PERIOD_MINMAX_EN
                  minp_d = (ecnt_n == '0) ? '0 : mn_n;
                  maxp_d = (ecnt_n == '0) ? '0 : mx_n;
`endif
               end
            end
         end
         default: ;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // synchronizer and edge-detect flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   // counters and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         glen_q  <= '0;
         tcnt_q  <= '0;
         gcnt_q  <= '0;
         ecnt_q  <= '0;
         pcnt_q  <= '0;
         last_q  <= '0;
         lper_q  <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         nosig_q <= 1'b0;
         ec_q    <= '0;
         sp_q    <= '0;
         lp_q    <= '0;
`ifdef PERIOD_MINMAX_EN
         mn_q   <= '0;
         mx_q   <= '0;
         minp_q <= '0;
         maxp_q <= '0;
`endif
      end else begin
         glen_q  <= glen_d;
         tcnt_q  <= tcnt_d;
         gcnt_q  <= gcnt_d;
         ecnt_q  <= ecnt_d;
         pcnt_q  <= pcnt_d;
         last_q  <= last_d;
         lper_q  <= lper_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         nosig_q <= nosig_d;
         ec_q    <= ec_d;
         sp_q    <= sp_d;
         lp_q    <= lp_d;
`ifdef PERIOD_MINMAX_EN
         mn_q   <= mn_d;
         mx_q   <= mx_d;
         minp_q <= minp_d;
         maxp_q <= maxp_d;
`endif
      end
   end

   assign bus.busy        = busy_q;
   assign bus.valid       = valid_q;
   assign bus.no_signal   = nosig_q;
   assign bus.edge_count  = ec_q;
   assign bus.span        = sp_q;
   assign bus.last_period = lp_q;
`ifdef PERIOD_MINMAX_EN
   assign bus.min_period  = minp_q;
   assign bus.max_period  = maxp_q;
`endif

endmodule
